// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA test-pattern source.
package vga_pkg;

   typedef enum logic [2:0] {
      SOLID_R  = 3'd0,
      SOLID_G  = 3'd1,
      SOLID_B  = 3'd2,
      BARS     = 3'd3,
      CHECKER  = 3'd4,
      GRADIENT = 3'd5
   } mode_e;

   localparam int NUM_MODES = 6;

   function automatic mode_e next_mode(input mode_e m);
      return (int'(m) == NUM_MODES - 1) ? SOLID_R : mode_e'(m + 3'd1);
   endfunction

   function automatic mode_e prev_mode(input mode_e m);
      return (m == SOLID_R) ? mode_e'(3'(NUM_MODES - 1)) : mode_e'(m - 3'd1);
   endfunction

   // Bar 0 is white and bar 7 is black: each channel flag is the inverted index bit.
   function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
      return ~bar;
   endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Two-flop synchroniser plus rising-edge detector for one raw push-button.
module key_edge_detect (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key,
   output logic o_rise
);

   logic sync1;
   logic sync2;
   logic last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         last  <= 1'b0;
      end else begin
         sync1 <= i_key;
         sync2 <= sync1;
         last  <= sync2;
      end
   end

   assign o_rise = sync2 & ~last;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: one registered RGB pixel per controller request,
// with key-selected mode/invert that only take effect at frame boundaries.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int COLOR_W    = 8,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int LEVEL      = 250,
   parameter int CHECK_LOG2 = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [2:0]           i_key,
   input  logic                 i_request,
   input  logic                 i_frame_sync,
   output logic [3*COLOR_W-1:0] o_color,
   output logic                 o_valid,
   output logic [2:0]           o_mode
);

   localparam int XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BAR_W = H_ACTIVE / 8;
   localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [COLOR_W-1:0] LVL  = COLOR_W'(LEVEL);
   localparam logic [COLOR_W-1:0] ZERO = '0;

   logic [2:0]           key_rise;
   logic [XW-1:0]        x;
   logic [YW-1:0]        y;
   logic [2:0]           bar;
   logic [BCW-1:0]       bar_cnt;
   logic                 x_last;
   logic                 y_last;
   logic                 boundary;
   mode_e                pend_mode;
   mode_e                pend_mode_nxt;
   mode_e                mode;
   logic                 pend_inv;
   logic                 pend_inv_nxt;
   logic                 inv;
   logic                 chk;
   logic [2:0]           rgb;
   logic [3*COLOR_W-1:0] pix;

   for (genvar k = 0; k < 3; k++) begin : g_key
      key_edge_detect u_key (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_key  (i_key[k]),
         .o_rise (key_rise[k])
      );
   end

   assign x_last   = (x == XW'(H_ACTIVE - 1));
   assign y_last   = (y == YW'(V_ACTIVE - 1));
   assign boundary = i_frame_sync | (i_request & x_last & y_last);

   // Raster position plus a bar tracker that avoids dividing x by the bar width.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x       <= '0;
         y       <= '0;
         bar     <= '0;
         bar_cnt <= '0;
      end else if (i_frame_sync) begin
         x       <= '0;
         y       <= '0;
         bar     <= '0;
         bar_cnt <= '0;
      end else if (i_request) begin
         if (x_last) begin
            x       <= '0;
            y       <= y_last ? '0 : y + 1'b1;
            bar     <= '0;
            bar_cnt <= '0;
         end else begin
            x <= x + 1'b1;
            if (bar != 3'd7) begin
               if (bar_cnt == BCW'(BAR_W - 1)) begin
                  bar     <= bar + 3'd1;
                  bar_cnt <= '0;
               end else begin
                  bar_cnt <= bar_cnt + 1'b1;
               end
            end
         end
      end
   end

   // Simultaneous next and prev presses cancel out.
   always_comb begin
      pend_mode_nxt = pend_mode;
      pend_inv_nxt  = pend_inv ^ key_rise[2];
      if (key_rise[0] && !key_rise[1]) begin
         pend_mode_nxt = next_mode(pend_mode);
      end else if (key_rise[1] && !key_rise[0]) begin
         pend_mode_nxt = prev_mode(pend_mode);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_mode <= SOLID_R;
         pend_inv  <= 1'b0;
         mode      <= SOLID_R;
         inv       <= 1'b0;
      end else begin
         pend_mode <= pend_mode_nxt;
         pend_inv  <= pend_inv_nxt;
         if (boundary) begin
            mode <= pend_mode_nxt;
            inv  <= pend_inv_nxt;
         end
      end
   end

   assign chk = 1'((32'(x) ^ 32'(y)) >> CHECK_LOG2);
   assign rgb = bar_rgb(bar);

   always_comb begin
      pix = '0;
      case (mode)
         SOLID_R:  pix = {LVL, ZERO, ZERO};
         SOLID_G:  pix = {ZERO, LVL, ZERO};
         SOLID_B:  pix = {ZERO, ZERO, LVL};
         BARS:     pix = {{COLOR_W{rgb[2]}}, {COLOR_W{rgb[1]}}, {COLOR_W{rgb[0]}}};
         CHECKER:  pix = {3*COLOR_W{chk}};
         GRADIENT: pix = {COLOR_W'(x), COLOR_W'(y), LVL};
         default:  pix = '0;
      endcase
   end

   // Colour holds between requests so the controller can sample it late.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_color <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= i_request;
         if (i_request) begin
            o_color <= inv ? ~pix : pix;
         end
      end
   end

   assign o_mode = mode;

endmodule
